alu_arb_ctrl: RTL

//  Round-robin arbiter/sequencer sharing one combinational W-bit ALU (3-bit alu_ch op select) between NREQ requesters.

---
 rtl/alu_arb_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between NREQ requesters.
// Optional macro ALU_ARB_FLAGS_EN: capture and return {zero,over,cout}; otherwise rsp_flags is 0.
module alu_arb_ctrl #(
  parameter int W    = 4,
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [W*NREQ-1:0]     req_a,
  input  logic [W*NREQ-1:0]     req_b,
  output logic [W-1:0]          alu_a,
  output logic [W-1:0]          alu_b,
  output logic [2:0]            alu_ch,
  input  logic [W-1:0]          alu_f,
  input  logic                  alu_zero,
  input  logic                  alu_over,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [W-1:0]          rsp_f,
  output logic [2:0]            rsp_flags
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]                state;
  logic [IDW-1:0]            rr_ptr;
  logic [IDW-1:0]            grant;
  logic                      any_vld;
  logic [NREQ-1:0][2:0]      op_arr;
  logic [NREQ-1:0][W-1:0]    a_arr;
  logic [NREQ-1:0][W-1:0]    b_arr;
  logic [IDW-1:0]            hi_id, lo_id;
  logic                      hi_hit, lo_hit;

  assign op_arr = req_op;
  assign a_arr  = req_a;
  assign b_arr  = req_b;

  // Two priority scans: first valid at/after rr_ptr, else first valid from 0 (the wrap).
  always_comb begin
    hi_id  = '0;
    lo_id  = '0;
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hi_hit && req_valid[i] && (i >= int'(rr_ptr))) begin
        hi_hit = 1'b1;
        hi_id  = IDW'(i);
      end
      if (!lo_hit && req_valid[i]) begin
        lo_hit = 1'b1;
        lo_id  = IDW'(i);
      end
    end
    any_vld = lo_hit;
    grant   = hi_hit ? hi_id : lo_id;
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_vld) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_f     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ch    <= '0;
    end else begin
      case (state)
        IDLE: if (any_vld) begin
          alu_ch <= op_arr[grant];
          alu_a  <= a_arr[grant];
          alu_b  <= b_arr[grant];
          rsp_id <= grant;
          state  <= EXEC;
        end
        EXEC: begin
          rsp_f     <= alu_f;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rr_ptr    <= (rsp_id == IDW'(NREQ-1)) ? '0 : rsp_id + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  logic [2:0] flags_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              flags_q <= '0;
    else if (state == EXEC)  flags_q <= {alu_zero, alu_over, alu_cout};
  end
  assign rsp_flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^{alu_zero, alu_over, alu_cout};
  assign rsp_flags    = 3'b000;
`endif

endmodule
